// File: rtl/score_pkg.sv
// Shared definitions for the judge -> arbiter -> score updater path.
package score_pkg;

  // Judgement grades as delivered by the lane judges.
  localparam logic [1:0] GRADE_NONE    = 2'b00;
  localparam logic [1:0] GRADE_MISS    = 2'b01;
  localparam logic [1:0] GRADE_GOOD    = 2'b10;
  localparam logic [1:0] GRADE_PERFECT = 2'b11;

  // Selector handed to the score updater; the encoding equals the grade so
  // an issued event can be forwarded without translation.
  typedef enum logic [1:0] {
    SEL_NONE    = 2'b00,
    SEL_MISS    = 2'b01,
    SEL_GOOD    = 2'b10,
    SEL_PERFECT = 2'b11
  } upd_sel_e;

  // A strobe with grade 00 carries no judgement and is ignored.
  function automatic logic grade_is_event(input logic [1:0] grade);
    return grade != GRADE_NONE;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin priority picker: grants the first requester at or above the
// pointer, wrapping from the top lane back to lane 0. Purely combinational.
module rr_arbiter #(
  parameter  int NUM_LANES = 4,
  localparam int LW        = $clog2(NUM_LANES)
) (
  input  logic [NUM_LANES-1:0] req_i,
  input  logic [LW-1:0]        ptr_i,
  output logic [NUM_LANES-1:0] gnt_o,
  output logic [LW-1:0]        gnt_idx_o,
  output logic                 any_gnt_o
);

  // Walk the lanes starting at the pointer; the first request found wins.
  always_comb begin
    int          lane;
    logic [LW-1:0] lane_idx;
    gnt_o     = '0;
    gnt_idx_o = '0;
    any_gnt_o = 1'b0;
    lane      = 0;
    lane_idx  = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      lane = int'(ptr_i) + k;
      if (lane >= NUM_LANES) begin
        lane = lane - NUM_LANES;
      end
      lane_idx = LW'(lane);
      if (!any_gnt_o && req_i[lane_idx]) begin
        any_gnt_o       = 1'b1;
        gnt_o[lane_idx] = 1'b1;
        gnt_idx_o       = lane_idx;
      end
    end
  end

endmodule

// File: rtl/score_event_arbiter.sv
// Serialises per-lane hit judgements into the single score/streak update
// path. Each lane owns a one-deep pending slot; a round-robin arbiter issues
// at most one event per clock. Events arriving at an occupied, non-granted
// slot are dropped and counted; game_active low flushes everything silently.
module score_event_arbiter #(
  parameter  int NUM_LANES = 4,
  parameter  int DROP_W    = 8,
  localparam int LW        = $clog2(NUM_LANES),
  localparam int CW        = $clog2(NUM_LANES + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   game_active,
  input  logic [NUM_LANES-1:0]   hit_valid,
  input  logic [2*NUM_LANES-1:0] hit_grade,
  output logic [1:0]             upd_sel,
  output logic [LW-1:0]          upd_lane,
  output logic [NUM_LANES-1:0]   pending,
  output logic [DROP_W-1:0]      drop_count,
  output logic                   overflow
);

  import score_pkg::*;

  logic [NUM_LANES-1:0]   pending_q, pending_d;
  logic [2*NUM_LANES-1:0] slot_q, slot_d;
  logic [LW-1:0]          rr_ptr_q, rr_ptr_d;
  upd_sel_e               upd_sel_q, upd_sel_d;
  logic [LW-1:0]          upd_lane_q, upd_lane_d;
  logic [DROP_W-1:0]      drop_q, drop_d;
  logic                   overflow_q, overflow_d;

  logic [NUM_LANES-1:0]   req;
  logic [NUM_LANES-1:0]   gnt;
  logic [LW-1:0]          gnt_idx;
  logic                   any_gnt;
  logic [CW-1:0]          n_drop;
  logic [DROP_W:0]        drop_sum;

  // Slots only compete while the song is playing; this also blocks issue
  // during a flush.
  assign req = pending_q & {NUM_LANES{game_active}};

  rr_arbiter #(
    .NUM_LANES (NUM_LANES)
  ) u_rr_arbiter (
    .req_i     (req),
    .ptr_i     (rr_ptr_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .any_gnt_o (any_gnt)
  );

  // Slot bookkeeping: release the granted slot, capture new judgements into
  // free (or just-freed) slots, count the ones that find their slot busy.
  always_comb begin
    logic [1:0] lane_grade;
    lane_grade = GRADE_NONE;
    pending_d  = pending_q & ~gnt;
    slot_d     = slot_q;
    n_drop     = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (gnt[i]) begin
        slot_d[2*i +: 2] = GRADE_NONE;
      end
    end
    if (!game_active) begin
      pending_d = '0;
    end else begin
      for (int i = 0; i < NUM_LANES; i++) begin
        lane_grade = hit_grade[2*i +: 2];
        if (hit_valid[i] && grade_is_event(lane_grade)) begin
          if (!pending_q[i] || gnt[i]) begin
            pending_d[i]     = 1'b1;
            slot_d[2*i +: 2] = lane_grade;
          end else begin
            n_drop = n_drop + CW'(1);
          end
        end
      end
    end
  end

  // Drop accounting saturates at all-ones; several lanes may drop at once.
  always_comb begin
    drop_sum   = {1'b0, drop_q} + (DROP_W + 1)'(n_drop);
    drop_d     = drop_sum[DROP_W] ? {DROP_W{1'b1}} : drop_sum[DROP_W-1:0];
    overflow_d = overflow_q | (n_drop != '0);
  end

  // Issue stage: forward the granted slot's grade and advance the pointer
  // past the winner; with no winner the lane index is left as it was.
  always_comb begin
    upd_sel_d  = SEL_NONE;
    upd_lane_d = upd_lane_q;
    rr_ptr_d   = rr_ptr_q;
    if (any_gnt) begin
      upd_sel_d  = upd_sel_e'(slot_q[2*gnt_idx +: 2]);
      upd_lane_d = gnt_idx;
      rr_ptr_d   = (gnt_idx == LW'(NUM_LANES - 1)) ? '0 : gnt_idx + LW'(1);
    end
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending_q  <= '0;
      slot_q     <= '0;
      rr_ptr_q   <= '0;
      upd_sel_q  <= SEL_NONE;
      upd_lane_q <= '0;
      drop_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      slot_q     <= slot_d;
      rr_ptr_q   <= rr_ptr_d;
      upd_sel_q  <= upd_sel_d;
      upd_lane_q <= upd_lane_d;
      drop_q     <= drop_d;
      overflow_q <= overflow_d;
    end
  end

  assign upd_sel    = upd_sel_q;
  assign upd_lane   = upd_lane_q;
  assign pending    = pending_q;
  assign drop_count = drop_q;
  assign overflow   = overflow_q;

endmodule
